fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-issue side of the Bitty core's run/done handshake: it owns the program counter, reads 16-bit instructions from instruction memory and presents each one on d_inst.
- It pulses run to the control FSM, waits for done, then advances the PC.
- For branch-format instructions (d_inst[1:0]=2'b10) it evaluates the branch condition against the ALU compare flags and loads the target address.
- It sits between instruction memory and the cpu control unit.

Parameters:
- ADDR_W, 8, program counter / memory address width.
- RESET_PC, 0, PC value loaded on reset.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- start  input  1  level; 1 = keep fetching/executing, 0 = stop at the next instruction boundary.
- mem_addr  output  ADDR_W  instruction memory address; always equals pc.
- mem_rd  output  1  read request; held high until mem_valid is seen.
- mem_rdata  input  16  instruction word; valid when mem_valid=1.
- mem_valid  input  1  read data valid; sampled only while mem_rd=1.
- d_inst  output  16  registered instruction presented to the cpu.
- run  output  1  one-cycle start pulse to the cpu.
- done  input  1  cpu completion pulse.
- flags  input  3  {lt, gt, eq} compare result from the ALU, sampled in UPDATE.
- pc  output  ADDR_W  current program counter.
- busy  output  1  high in every state except IDLE.
- br_taken  output  1  one-cycle pulse in the cycle a branch target is loaded.
- inst_cnt  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (reset=0 at a clock edge, from any state):
  - state=IDLE, pc=RESET_PC, d_inst=0, mem_rd=0, run=0, br_taken=0, inst_cnt=0, busy=0.
  - Takes effect at that edge, including mid-fetch or mid-execution.
  - A done arriving afterwards is ignored.
- States: IDLE, REQ, ISSUE, EXEC, UPDATE.
- IDLE: mem_rd=0. If start=1, go to REQ.
- REQ:
  - mem_rd=1, mem_addr=pc.
  - When mem_valid=1 in this state: d_inst <= mem_rdata and go to ISSUE.
  - Otherwise stay in REQ with mem_rd held high (unbounded wait states).
- ISSUE: run=1 for exactly this one cycle, then go to EXEC. d_inst is stable from ISSUE through UPDATE.
- EXEC:
  - run=0; wait for done=1, then go to UPDATE.
  - done in any other state is ignored.
  - done in the ISSUE cycle is ignored; the cpu cannot complete in 0 cycles.
- UPDATE, next PC:
  - If d_inst[1:0]=2'b10 (branch): cond=d_inst[3:2], target=d_inst[11:4] zero-extended or truncated to ADDR_W.
  - cond 00 = take if eq; 01 = take if gt; 10 = take if lt; 11 = never taken.
  - Taken: pc <= target and br_taken=1 in this cycle.
  - Not taken, or non-branch format: pc <= pc+1, modulo 2^ADDR_W (wraps from all-ones to 0).
  - inst_cnt <= inst_cnt+1, wrapping.
  - Then: start=1 -> REQ; start=0 -> IDLE.
- start is sampled only in IDLE and UPDATE. Dropping start mid-instruction completes that instruction and its PC update.
- Timing with a zero-wait memory (mem_valid returned in the first REQ cycle):
  - Per instruction: REQ 1 + ISSUE 1 + EXEC N + UPDATE 1 cycles, where N is the cycles until done.
  - run rises 1 cycle after REQ entry.
- busy is a pure function of state: 1 in REQ, ISSUE, EXEC and UPDATE.
- All outputs are registered or decoded from state only; there is no combinational path from an input to run or mem_rd.

Test Plan:
- Zero-wait memory holding 3 ALU ops at addresses 0-2, start=1, cpu model returns done 2 cycles after run:
  - exactly one run pulse per instruction; mem_addr sequence 0,1,2,3;
  - inst_cnt=3 after the third UPDATE;
  - d_inst matches each memory word while run=1.
- Branch taken: instruction at pc=4 is 16'h0A02 (format 10, cond 00, target 0xA0), flags=3'b001 at UPDATE:
  - pc=0xA0 the next cycle; br_taken pulses for 1 cycle; next mem_addr=0xA0.
- Same instruction with flags=3'b100, and cond=11 with flags=3'b111:
  - pc=5 in both cases; br_taken stays 0.
- Memory with 3 wait states (mem_valid 3 cycles after mem_rd rises):
  - mem_rd held high for 4 cycles; run asserted only in the cycle after mem_valid;
  - spurious mem_valid while in IDLE has no effect.
- pc=8'hFF with a non-branch instruction: pc=8'h00 after UPDATE; a stray done in REQ does not advance the state.
- Reset and start control:
  - reset=0 asserted in EXEC with pc=7: next cycle pc=0, state IDLE, run=0, inst_cnt=0.
  - Separately, start dropped in EXEC: the instruction finishes, pc increments, the block returns to IDLE, and mem_rd stays 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory bus and cpu run/done handshake seen by the fetch sequencer.
// master = sequencer side, slave = memory/cpu side.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [15:0]       mem_rdata;
    logic              mem_valid;
    logic [15:0]       d_inst;
    logic              run;
    logic              done;
    logic [2:0]        flags;

    modport master (
        output mem_addr, mem_rd, d_inst, run,
        input  mem_rdata, mem_valid, done, flags
    );

    modport slave (
        input  mem_addr, mem_rd, d_inst, run,
        output mem_rdata, mem_valid, done, flags
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches 16-bit words, issues them to the cpu
// with a run pulse, waits for done, then steps or branches the PC.
module fetch_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    fetch_sequencer_if.master  bus,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               br_taken,
    output logic [CNT_W-1:0]   inst_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ    = 3'd1;
    localparam logic [2:0] S_ISSUE  = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         inst_q, inst_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cond_hit;
    logic                taken;
    logic [ADDR_W+7:0]   tgt_ext;
    logic [ADDR_W-1:0]   target;

    // Branch target is zero-extended or truncated to the PC width.
    assign tgt_ext = {{ADDR_W{1'b0}}, inst_q[11:4]};
    assign target  = tgt_ext[ADDR_W-1:0];

    // Branch decision: cond selects one compare flag, cond 11 never taken.
    always_comb begin
        cond_hit = 1'b0;
        unique case (inst_q[3:2])
            2'b00:   cond_hit = bus.flags[0];
            2'b01:   cond_hit = bus.flags[1];
            2'b10:   cond_hit = bus.flags[2];
            default: cond_hit = 1'b0;
        endcase
        taken = (state_q == S_UPDATE) && (inst_q[1:0] == 2'b10) && cond_hit;
    end

    // Next-state, PC, instruction latch and retire counter.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                if (bus.mem_valid) begin
                    inst_d  = bus.mem_rdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.done) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                pc_d    = taken ? target : pc_q + ADDR_W'(1);
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = start ? S_REQ : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            inst_q  <= 16'h0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_addr = pc_q;
    assign bus.mem_rd   = (state_q == S_REQ);
    assign bus.run      = (state_q == S_ISSUE);
    assign bus.d_inst   = inst_q;
    assign pc           = pc_q;
    assign busy         = (state_q != S_IDLE);
    assign br_taken     = taken;
    assign inst_cnt     = cnt_q;

endmodule
